// File: rtl/ahblite_timer_slave.sv
// ahblite_timer_slave: AHB-Lite 32-bit down-counting timer with prescaler, interrupt, wait states and ERROR response
// Bus side: HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY in, HREADYOUT/HRESP/HRDATA out; TIMER_IRQ is the level interrupt
module ahblite_timer_slave #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_BITS = 12
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        TIMER_IRQ
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state_q, state_d;
  logic [1:0] addr_q, addr_d, wcnt_q, wcnt_d;
  logic write_q, write_d;
  logic en_q, en_d, ie_q, ie_d, per_q, per_d, flag_q, flag_d, irq_q, irq_d;
  logic [7:0] pre_q, pre_d, pcnt_q, pcnt_d;
  logic [31:0] load_q, load_d, value_q, value_d, rdata;
  logic accept, legal, we, wr_ctrl, wr_load, wr_int, tick, set, en_clr;
  logic unused_ok;
  assign unused_ok = ^{HPROT, HADDR[31:ADDR_BITS], HADDR[1:0]};
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign legal = HSIZE == 3'b010 && HADDR[ADDR_BITS-1:4] == '0 && !(HWRITE && HADDR[3:2] == 2'd2);
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wcnt_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wcnt_q <= wcnt_d;
      write_q <= write_d;
    end
  // WAIT and ERR1 drive HREADYOUT low, so no new transfer can be accepted there
  always_comb begin
    state_d = S_IDLE;
    addr_d = addr_q;
    write_d = write_q;
    wcnt_d = wcnt_q;
    if (state_q == S_WAIT) begin
      wcnt_d = wcnt_q - 2'd1;
      state_d = wcnt_q == 2'd1 ? S_DATA : S_WAIT;
    end else if (state_q == S_ERR1)
      state_d = S_ERR2;
    else if (accept) begin
      addr_d = HADDR[3:2];
      write_d = HWRITE;
      wcnt_d = 2'(WAIT_STATES);
      state_d = !legal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
    end
  end
  always_comb begin
    HREADYOUT = !(state_q inside {S_WAIT, S_ERR1});
    HRESP = state_q inside {S_ERR1, S_ERR2};
    HRDATA = state_q == S_DATA ? rdata : '0;
  end
  assign rdata = addr_q == 2'd0 ? {16'd0, pre_q, 5'd0, per_q, ie_q, en_q} :
                 addr_q == 2'd1 ? load_q :
                 addr_q == 2'd2 ? value_q : {31'd0, flag_q};
  assign we = state_q == S_DATA && write_q;
  assign wr_ctrl = we && addr_q == 2'd0;
  assign wr_load = we && addr_q == 2'd1;
  assign wr_int = we && addr_q == 2'd3;
  assign tick = en_q && pcnt_q == pre_q;
  // A LOAD write takes priority over a same-edge tick; a flag set beats a same-edge W1C
  always_comb begin
    pcnt_d = (!en_q || tick || wr_load) ? 8'd0 : pcnt_q + 8'd1;
    value_d = value_q;
    set = 1'b0;
    en_clr = 1'b0;
    if (wr_load)
      value_d = HWDATA;
    else if (tick) begin
      value_d = value_q > 32'd1 ? value_q - 32'd1 : value_q == 32'd1 ? 32'd0 : per_q ? load_q : 32'd0;
      set = value_q == 32'd1 || (value_q == 32'd0 && per_q && load_q == 32'd0);
      en_clr = value_q == 32'd0 && !per_q;
    end
    flag_d = set | (flag_q & !(wr_int & HWDATA[0]));
    en_d = wr_ctrl ? HWDATA[0] : en_q & !en_clr;
    ie_d = wr_ctrl ? HWDATA[1] : ie_q;
    per_d = wr_ctrl ? HWDATA[2] : per_q;
    pre_d = wr_ctrl ? HWDATA[15:8] : pre_q;
    load_d = wr_load ? HWDATA : load_q;
    irq_d = flag_q & ie_q;
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      en_q <= 1'b0;
      ie_q <= 1'b0;
      per_q <= 1'b0;
      pre_q <= '0;
      pcnt_q <= '0;
      load_q <= '0;
      value_q <= '0;
      flag_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      en_q <= en_d;
      ie_q <= ie_d;
      per_q <= per_d;
      pre_q <= pre_d;
      pcnt_q <= pcnt_d;
      load_q <= load_d;
      value_q <= value_d;
      flag_q <= flag_d;
      irq_q <= irq_d;
    end
  assign TIMER_IRQ = irq_q;
endmodule

// File: tb/tb_ahblite_timer_slave.sv
// tb_ahblite_timer_slave: scoreboard bench for the AHB-Lite timer, zero-wait and two-wait instances
module tb_ahblite_timer_slave;
  logic clk = 0, rst = 1, hsel = 0, hwrite = 0, sel2 = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 3'b010;
  logic [3:0] hprot = 0;
  logic ro0, ro2, rs0, rs2, irq0, irq2, ro, rs, irq;
  logic [31:0] rd0, rd2, rd;
  assign ro = sel2 ? ro2 : ro0;
  assign rs = sel2 ? rs2 : rs0;
  assign rd = sel2 ? rd2 : rd0;
  assign irq = sel2 ? irq2 : irq0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  bit op_wr[16];
  logic [31:0] op_addr[16], op_wd[16], res_rd[16];
  logic [2:0] op_sz[16];
  int res_lo[16];
  bit res_elo[16], res_ehi[16], res_irq[16];

  ahblite_timer_slave #(.WAIT_STATES(0), .ADDR_BITS(12)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~sel2), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro), .HREADYOUT(ro0), .HRDATA(rd0),
    .HRESP(rs0), .TIMER_IRQ(irq0));
  ahblite_timer_slave #(.WAIT_STATES(2), .ADDR_BITS(12)) dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & sel2), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ro), .HREADYOUT(ro2), .HRDATA(rd2),
    .HRESP(rs2), .TIMER_IRQ(irq2));

  task automatic set_op(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    op_wr[i] = wr;
    op_addr[i] = a;
    op_wd[i] = d;
    op_sz[i] = sz;
  endtask

  // Pipelined master: address phase of op i overlaps the data phase of op i-1
  task automatic run(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hsel = 1; htrans = 2'b10; haddr = op_addr[i]; hwrite = op_wr[i]; hsize = op_sz[i];
      end else begin
        hsel = 0; htrans = 2'b00;
      end
      if (i > 0) begin
        bit got = 0;
        hwdata = op_wd[i-1];
        res_lo[i-1] = 0;
        res_elo[i-1] = 0;
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge clk);
          if (ro) begin
            got = 1;
            res_rd[i-1] = rd;
            res_ehi[i-1] = rs;
            res_irq[i-1] = irq;
          end else begin
            res_lo[i-1]++;
            res_elo[i-1] |= rs;
          end
        end
        if (!got) begin
          total++; bad++;
          $display("FAIL timeout op%0d: hready stayed 0 for 20 cycles, want 1", i-1);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ro0, rs0, irq0, rd0} !== {3'b100, 32'd0}) begin
      bad++; $display("FAIL reset_out0: got %b %b %b %h want 1 0 0 0", ro0, rs0, irq0, rd0);
    end
    total++;
    if ({ro2, rs2, irq2, rd2} !== {3'b100, 32'd0}) begin
      bad++; $display("FAIL reset_out2: got %b %b %b %h want 1 0 0 0", ro2, rs2, irq2, rd2);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      set_op(i, 0, 32'(i * 4), 0, 3'b010);
      exp_q.push_back(32'd0);
    end
    run(4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e = exp_q.pop_front();
      total++;
      if (res_rd[i] !== e || res_lo[i] != 0 || res_ehi[i] !== 1'b0) begin
        bad++; $display("FAIL reset_read%0d: got %h waits=%0d resp=%b want %h 0 0", i, res_rd[i], res_lo[i], res_ehi[i], e);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] ev[9] = '{5, 4, 3, 2, 1, 0, 0, 2, 1};
    set_op(0, 1, 32'h4, 5, 3'b010);
    set_op(1, 1, 32'h0, 3, 3'b010);
    for (int i = 0; i < 9; i++) begin
      set_op(i + 2, 0, i < 7 ? 32'h8 : i == 7 ? 32'h0 : 32'hC, 0, 3'b010);
      exp_q.push_back(ev[i]);
    end
    run(11);
    for (int i = 2; i < 11; i++) begin
      logic [31:0] e = exp_q.pop_front();
      total++;
      if (res_rd[i] !== e || res_lo[i] != 0) begin
        bad++; $display("FAIL oneshot_read%0d: got %h waits=%0d want %h 0", i, res_rd[i], res_lo[i], e);
      end
    end
    total++;
    if ({res_irq[7], res_irq[8]} !== 2'b01) begin
      bad++; $display("FAIL oneshot_irq_delay: got %b%b want 01", res_irq[7], res_irq[8]);
    end
    set_op(0, 1, 32'hC, 1, 3'b010);
    run(1);
    total++;
    if (irq0 !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b want 1", irq0); end
    @(posedge clk); #1;
    total++;
    if (irq0 !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq0); end
  endtask

  task automatic test_periodic;
    int idl[8] = '{0, 2, 0, 0, 0, 0, 2, 2};
    bit wr[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic [31:0] ad[8] = '{8, 8, 12, 12, 8, 8, 8, 8};
    logic [31:0] ev[8] = '{2, 1, 0, 1, 0, 2, 1, 0};
    set_op(0, 1, 32'h4, 2, 3'b010);
    set_op(1, 1, 32'h0, 32'h305, 3'b010);
    run(2);
    for (int s = 0; s < 8; s++) begin
      repeat (idl[s]) @(posedge clk);
      if (idl[s] > 0) #1;
      set_op(0, wr[s], ad[s], 1, 3'b010);
      if (!wr[s]) exp_q.push_back(ev[s]);
      run(1);
      if (!wr[s]) begin
        logic [31:0] e = exp_q.pop_front();
        total++;
        if (res_rd[0] !== e) begin
          bad++; $display("FAIL periodic_step%0d: got %h want %h", s, res_rd[0], e);
        end
      end
    end
    set_op(0, 1, 32'h0, 0, 3'b010);
    set_op(1, 1, 32'hC, 1, 3'b010);
    run(2);
  endtask

  task automatic test_errors;
    set_op(0, 1, 32'h4, 32'h55, 3'b010);
    set_op(1, 1, 32'h0, 0, 3'b010);
    run(2);
    set_op(0, 1, 32'h8, 32'h1234, 3'b010);
    set_op(1, 0, 32'h0, 0, 3'b001);
    set_op(2, 1, 32'h20, 32'h305, 3'b010);
    run(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (res_lo[i] != 1 || res_elo[i] !== 1'b1 || res_ehi[i] !== 1'b1) begin
        bad++; $display("FAIL error%0d: got waits=%0d resp=%b%b want 1 11", i, res_lo[i], res_elo[i], res_ehi[i]);
      end
    end
    set_op(0, 0, 32'h4, 0, 3'b010); exp_q.push_back(32'h55);
    set_op(1, 0, 32'h8, 0, 3'b010); exp_q.push_back(32'h55);
    set_op(2, 0, 32'h0, 0, 3'b010); exp_q.push_back(32'h0);
    run(3);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e = exp_q.pop_front();
      total++;
      if (res_rd[i] !== e || res_ehi[i] !== 1'b0) begin
        bad++; $display("FAIL error_noeffect%0d: got %h resp=%b want %h 0", i, res_rd[i], res_ehi[i], e);
      end
    end
  endtask

  task automatic test_wait_states;
    sel2 = 1;
    set_op(0, 1, 32'h4, 32'hA5A5_0000, 3'b010);
    set_op(1, 0, 32'h4, 0, 3'b010); exp_q.push_back(32'hA5A5_0000);
    set_op(2, 0, 32'h8, 0, 3'b010); exp_q.push_back(32'hA5A5_0000);
    run(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (res_lo[i] != 2 || res_ehi[i] !== 1'b0) begin
        bad++; $display("FAIL ws_waits%0d: got waits=%0d resp=%b want 2 0", i, res_lo[i], res_ehi[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      logic [31:0] e = exp_q.pop_front();
      total++;
      if (res_rd[i] !== e) begin bad++; $display("FAIL ws_read%0d: got %h want %h", i, res_rd[i], e); end
    end
    sel2 = 0;
  endtask

  task automatic test_reset_mid;
    sel2 = 1;
    hsel = 1; htrans = 2'b10; haddr = 32'h4; hwrite = 1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hwdata = 32'h1234;
    total++;
    if (ro2 !== 1'b0) begin bad++; $display("FAIL mid_wait: got hready %b want 0", ro2); end
    #1 rst = 1;
    #1;
    total++;
    if (ro2 !== 1'b1 || rs2 !== 1'b0) begin bad++; $display("FAIL mid_reset: got %b %b want 1 0", ro2, rs2); end
    @(posedge clk); #1 rst = 0;
    set_op(0, 0, 32'h4, 0, 3'b010); exp_q.push_back(32'h0);
    run(1);
    begin
      logic [31:0] e = exp_q.pop_front();
      total++;
      if (res_rd[0] !== e) begin bad++; $display("FAIL mid_load: got %h want %h", res_rd[0], e); end
    end
    sel2 = 0;
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_errors;
    test_wait_states;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
